pwm_capture: RTL



---
 rtl/pwm_pkg.sv | 13 +
 rtl/pwm_capture_sync2.sv | 22 ++
 rtl/pwm_capture.sv | 113 +++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM capture block: FSM encoding and default width.
package pwm_pkg;

   // Default width of the measured period/duty values, in clock cycles.
   localparam int unsigned pwmN = 8;

   // IDLE waits for the first rising edge; MEAS accumulates a window.
   typedef enum logic {
      IDLE = 1'b0,
      MEAS = 1'b1
   } state_t;

endpackage

// File: rtl/pwm_capture_sync2.sv
// Two-flop synchronizer with asynchronous active-low clear.
module sync2 (
   input  logic clk,
   input  logic clr,
   input  logic d,
   output logic q
);

   logic meta;

   // Two-stage capture of the asynchronous input; both stages clear together.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/pwm_capture.sv
// PWM capture: measures period and high time of pwm_in between successive
// rising edges, with saturation/timeout reporting for static inputs.
module pwm_capture
   import pwm_pkg::*;
#(
   parameter int unsigned N = pwmN
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         pwm_in,
   output logic [N-1:0] period,
   output logic [N-1:0] duty,
   output logic         valid,
   output logic         ovf
);

   localparam logic [N-1:0] CNT_MAX = '1;
   localparam logic [N-1:0] CNT_ONE = N'(1);

   state_t       state, state_next;
   logic         s;
   logic         s_prev;
   logic         rise;
   logic [N-1:0] period_cnt, period_cnt_next;
   logic [N-1:0] high_cnt, high_cnt_next;
   logic [N-1:0] period_next, duty_next;
   logic         valid_next, ovf_next;

   sync2 u_sync (
      .clk (clk),
      .clr (clr),
      .d   (pwm_in),
      .q   (s)
   );

   // Previous synchronized sample for rising-edge detection.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         s_prev <= 1'b0;
      end else begin
         s_prev <= s;
      end
   end

   assign rise = s & ~s_prev;

   // State, counters and reported results.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state      <= IDLE;
         period_cnt <= '0;
         high_cnt   <= '0;
         period     <= '0;
         duty       <= '0;
         valid      <= 1'b0;
         ovf        <= 1'b0;
      end else begin
         state      <= state_next;
         period_cnt <= period_cnt_next;
         high_cnt   <= high_cnt_next;
         period     <= period_next;
         duty       <= duty_next;
         valid      <= valid_next;
         ovf        <= ovf_next;
      end
   end

   // Next-state and result computation; an edge takes priority over timeout.
   always_comb begin
      state_next      = state;
      period_cnt_next = period_cnt;
      high_cnt_next   = high_cnt;
      period_next     = period;
      duty_next       = duty;
      ovf_next        = ovf;
      valid_next      = 1'b0;
      unique case (state)
         IDLE: begin
            if (rise) begin
               state_next      = MEAS;
               period_cnt_next = CNT_ONE;
               high_cnt_next   = CNT_ONE;
            end
         end
         MEAS: begin
            if (rise) begin
               period_next     = period_cnt;
               duty_next       = high_cnt;
               ovf_next        = 1'b0;
               valid_next      = 1'b1;
               period_cnt_next = CNT_ONE;
               high_cnt_next   = CNT_ONE;
            end else if (period_cnt == CNT_MAX) begin
               // Saturated window: report the level held at timeout, not high_cnt.
               period_next     = CNT_MAX;
               duty_next       = s ? CNT_MAX : '0;
               ovf_next        = 1'b1;
               valid_next      = 1'b1;
               period_cnt_next = '0;
               high_cnt_next   = '0;
               state_next      = IDLE;
            end else begin
               period_cnt_next = period_cnt + CNT_ONE;
               high_cnt_next   = high_cnt + N'(s);
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

endmodule
